// File: rtl/alu_operand_regfile.sv
// Register file feeding registered ALU operands a/b, with same-cycle write-through
// from the write-back bus and an immediate select for operand b.
module alu_operand_regfile #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] bus,
   input  logic [4:0]      rd,
   input  logic            rd_we,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [XLEN-1:0] imm,
   input  logic            b_imm,
   input  logic            lat_en,
   output logic [XLEN-1:0] a,
   output logic [XLEN-1:0] b,
   output logic            valid
);

   localparam int unsigned IdxW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic            valid_q;
   logic            wr_hit;
   logic            rs1_ok, rs2_ok;

   assign wr_hit = rd_we && (rd != 5'd0) && (32'(rd) < NREG);
   assign rs1_ok = (rs1 != 5'd0) && (32'(rs1) < NREG);
   assign rs2_ok = (rs2 != 5'd0) && (32'(rs2) < NREG);

   // Out-of-range and x0 indices read as zero; a pending write forwards the bus.
   always_comb begin
      a_d = '0;
      b_d = '0;
      if (rs1_ok) begin
         if (wr_hit && (rs1 == rd)) begin
            a_d = bus;
         end else begin
            a_d = regs_q[rs1[IdxW-1:0]];
         end
      end
      if (b_imm) begin
         b_d = imm;
      end else if (rs2_ok) begin
         if (wr_hit && (rs2 == rd)) begin
            b_d = bus;
         end else begin
            b_d = regs_q[rs2[IdxW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs_q[i] <= '0;
         end
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         if (wr_hit) begin
            regs_q[rd[IdxW-1:0]] <= bus;
         end
         if (lat_en) begin
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= 1'b1;
         end
      end
   end

   assign a     = a_q;
   assign b     = b_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Randomised scoreboard bench for alu_operand_regfile built with NREG=16 (RV32E).
module tb_alu_operand_regfile;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 16;

   logic            clk;
   logic            rst;
   logic [XLEN-1:0] bus;
   logic [4:0]      rd;
   logic            rd_we;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [XLEN-1:0] imm;
   logic            b_imm;
   logic            lat_en;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            valid;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic            v;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   pushed = 0;
   int   popped = 0;

   logic [XLEN-1:0] m_reg [32];
   logic [XLEN-1:0] m_a, m_b;
   logic            m_v;

   alu_operand_regfile #(
      .XLEN(XLEN),
      .NREG(NREG)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .rd    (rd),
      .rd_we (rd_we),
      .rs1   (rs1),
      .rs2   (rs2),
      .imm   (imm),
      .b_imm (b_imm),
      .lat_en(lat_en),
      .a     (a),
      .b     (b),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural view of one edge: what the operand read sees this cycle.
   function automatic logic [XLEN-1:0] model_read(input int idx, input bit wr, input int widx,
                                                  input logic [XLEN-1:0] wdata);
      if (idx == 0 || idx >= int'(NREG)) return '0;
      if (wr && idx == widx) return wdata;
      return m_reg[idx];
   endfunction

   task automatic cycle(input bit r, input bit we, input int d, input logic [XLEN-1:0] dat,
                        input int s1, input int s2, input logic [XLEN-1:0] im, input bit bi,
                        input bit le);
      exp_t e;
      bit   wr;
      @(negedge clk);
      rst = r; rd_we = we; rd = 5'(d); bus = dat; rs1 = 5'(s1); rs2 = 5'(s2);
      imm = im; b_imm = bi; lat_en = le;
      if (r) begin
         for (int i = 0; i < 32; i++) m_reg[i] = '0;
         m_a = '0; m_b = '0; m_v = 1'b0;
      end else begin
         wr = we && d != 0 && d < int'(NREG);
         if (le) begin
            m_a = model_read(s1, wr, d, dat);
            m_b = bi ? im : model_read(s2, wr, d, dat);
            m_v = 1'b1;
         end
         if (wr) m_reg[d] = dat;
      end
      e.a = m_a; e.b = m_b; e.v = m_v;
      exp_q.push_back(e);
      pushed++;
   endtask

   // Monitor: one expected snapshot per clock edge, sampled just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            popped++;
            checks++;
            if (a !== e.a) begin
               errors++;
               $display("FAIL a @%0t: got %h expected %h", $time, a, e.a);
            end
            checks++;
            if (b !== e.b) begin
               errors++;
               $display("FAIL b @%0t: got %h expected %h", $time, b, e.b);
            end
            checks++;
            if (valid !== e.v) begin
               errors++;
               $display("FAIL valid @%0t: got %b expected %b", $time, valid, e.v);
            end
         end
      end
   end

   initial begin
      int d, s1, s2;
      rst = 1'b1; rd_we = 1'b0; rd = '0; bus = '0; rs1 = '0; rs2 = '0;
      imm = '0; b_imm = 1'b0; lat_en = 1'b0;
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_a = '0; m_b = '0; m_v = 1'b0;
      @(posedge clk);

      //    rst we rd  bus            rs1 rs2 imm            bi le
      cycle(1, 0, 0,  32'h0,         0,  0,  32'h0,         0, 0);
      cycle(1, 0, 0,  32'h0,         0,  0,  32'h0,         0, 0);
      cycle(0, 0, 0,  32'h0,         3,  4,  32'h0,         0, 1);
      cycle(0, 1, 5,  32'h0000_00AA, 0,  0,  32'h0,         0, 0);
      cycle(0, 0, 0,  32'h0,         5,  0,  32'h0,         0, 1);
      cycle(0, 1, 7,  32'h1234_5678, 7,  7,  32'h0,         0, 1);
      cycle(0, 1, 0,  32'hFFFF_FFFF, 0,  0,  32'h0,         0, 1);
      cycle(0, 0, 0,  32'h0,         0,  0,  32'h0,         0, 1);
      cycle(0, 1, 20, 32'hDEAD_BEEF, 20, 20, 32'h0,         0, 1);
      cycle(0, 0, 0,  32'h0,         20, 20, 32'h0,         0, 1);
      cycle(0, 1, 15, 32'hCAFE_F00D, 15, 15, 32'h0,         0, 1);
      cycle(0, 1, 7,  32'h5555_AAAA, 5,  7,  32'hFFFF_F800, 1, 1);
      cycle(0, 1, 5,  32'h0BAD_0BAD, 5,  5,  32'h0,         0, 0);
      cycle(0, 0, 0,  32'h0,         5,  5,  32'h0,         0, 0);
      cycle(1, 1, 9,  32'h9999_9999, 7,  9,  32'h0,         0, 1);
      cycle(0, 0, 0,  32'h0,         7,  5,  32'h0,         0, 1);
      cycle(0, 1, 3,  32'h0000_0003, 3,  3,  32'h7FFF_FFFF, 1, 1);
      cycle(0, 1, 4,  32'h8000_0000, 3,  4,  32'h0,         0, 1);

      for (int n = 0; n < 600; n++) begin
         d  = int'($urandom_range(0, 31));
         s1 = ($urandom_range(0, 2) == 0) ? d : int'($urandom_range(0, 31));
         s2 = ($urandom_range(0, 2) == 0) ? d : int'($urandom_range(0, 31));
         cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), d, $urandom(),
               s1, s2, $urandom(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));
      end

      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (popped != pushed || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: popped %0d expected %0d", popped, pushed);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_operand_regfile.md
ALU_OPERAND_REGFILE -- requirements
Module: alu_operand_regfile

Interface
REQ-001 Parameter XLEN, default 32: data width of registers, bus and operands.
REQ-002 Parameter NREG, default 32: number of architectural registers (16 for RV32E); register index ports stay 5 bits wide.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 bus  input  XLEN  write-back data (ALU result or memory data).
REQ-006 rd  input  5  destination register index.
REQ-007 rd_we  input  1  write bus into register rd this cycle.
REQ-008 rs1  input  5  source index for operand a.
REQ-009 rs2  input  5  source index for operand b.
REQ-010 imm  input  XLEN  immediate operand.
REQ-011 b_imm  input  1  select imm instead of register rs2 for operand b.
REQ-012 lat_en  input  1  capture new operands into the a/b latches this cycle.
REQ-013 a  output  XLEN  registered operand a, driving the ALU a input.
REQ-014 b  output  XLEN  registered operand b, driving the ALU b input.
REQ-015 valid  output  1  high while a/b hold operands captured since the last reset.

Function
REQ-016 Register file: NREG x XLEN state; x0 reads as 0 at all times.
REQ-017 Write: rd_we=1, rd!=0 and rd<NREG at an edge -> reg[rd]<=bus.
REQ-018 Write ignored in all other cases: rd=0, rd>=NREG, or rd_we=0.
REQ-019 Read: an index of 0 or an index >= NREG yields 0.
REQ-020 Latch: lat_en=1 at an edge -> a<=read(rs1).
REQ-021 Latch, operand b: lat_en=1 at an edge -> b<=(b_imm ? imm : read(rs2)).
REQ-022 Latency: operands appear on a/b exactly one cycle after the lat_en edge.
REQ-023 Hold: lat_en=0 -> a and b hold their values, regardless of register writes.
REQ-024 Write-through: rd_we and lat_en in the same cycle with rs1==rd (rd valid, nonzero) -> a captures bus, not the old register value.
REQ-025 Write-through, operand b: same rule as REQ-024 for rs2==rd when b_imm=0.
REQ-026 Write-through never applies to rd=0 or rd>=NREG; those reads still yield 0.
REQ-027 b_imm=1 ignores rs2 completely, including write-through.
REQ-028 valid: set at the first lat_en edge after reset, then stays 1 until the next reset.
REQ-029 No arithmetic in this block; values pass bit-exact with no sign or width change.
REQ-030 Back-to-back: lat_en held high for consecutive cycles re-captures every cycle, with no bubble.

Reset
REQ-031 rst=1 at an edge clears all registers, a, b and valid to 0.
REQ-032 rst takes priority over rd_we and lat_en in the same cycle; neither a write nor a latch occurs.
REQ-033 Reset asserted mid-operation loses all operand and register state; the first lat_en after rst falls reads zeros unless registers were rewritten.

Verification
REQ-034 Reset then lat_en, rs1=3, rs2=4 -> next cycle a=0, b=0, valid=1.
REQ-035 Write x5=0x0000_00AA, later lat_en rs1=5, rs2=0 -> a=0xAA, b=0.
REQ-036 Same cycle: rd_we, rd=7, bus=0x1234_5678, lat_en rs1=7, rs2=7 -> a=b=0x1234_5678.
REQ-037 Write attempt rd=0, bus=0xFFFF_FFFF -> a later read of x0 gives 0; NREG=16 write to rd=20 is dropped and reads of 20 give 0.
REQ-038 b_imm=1, imm=0xFFFF_F800, rs2=7 (x7 nonzero) -> b=0xFFFF_F800.
REQ-039 lat_en=0 while writing rs1's register -> a unchanged; rst with rd_we and lat_en both high -> everything 0.
